myproject_sdiv_22s_8ns_14_seq: RTL and testbench

Sequential signed-by-unsigned integer divider for the LayerNorm datapath. It is the inverse of the signed×unsigned product cores and recovers normalized values from scaled sums. Each operation takes a signed dividend and an unsigned divisor and produces a truncated quotient, a remainder and a divide-by-zero flag. Operands enter and results leave through valid/ready handshakes; the core computes one quotient bit per cycle using restoring division on magnitudes.

---
 rtl/myproject_sdiv_22s_8ns_14_seq_if.sv | 27 ++
 rtl/myproject_sdiv_22s_8ns_14_seq.sv | 171 +++++++++++++++++
 tb/tb_myproject_sdiv_22s_8ns_14_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/myproject_sdiv_22s_8ns_14_seq_if.sv
// Operand/result handshake bundle for the sequential signed-by-unsigned divider.
// The master drives operands and out_ready; the slave (the divider) drives results.
interface myproject_sdiv_22s_8ns_14_seq_if #(
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH:0]   rem;
    logic                  dbz;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, rem, dbz
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, rem, dbz
    );
endinterface

// File: rtl/myproject_sdiv_22s_8ns_14_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle on magnitudes.
// Define MYPROJECT_SDIV_SAT_EN to clamp the narrowed quotient instead of wrapping it.
module myproject_sdiv_22s_8ns_14_seq #(
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 14
) (
    input logic ap_clk,
    input logic ap_rst_n,
    myproject_sdiv_22s_8ns_14_seq_if.slave bus
);
    localparam int CNT_W = $clog2(din0_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(din0_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [din0_WIDTH-1:0] mag_q, mag_d;
    logic [din1_WIDTH-1:0] part_q, part_d;
    logic [din1_WIDTH-1:0] div_q, div_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [din1_WIDTH:0]   rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [din0_WIDTH-1:0] mag_in;
    logic [din1_WIDTH:0]   shifted;
    logic                  q_bit;
    logic [din1_WIDTH-1:0] part_next;
    logic [din0_WIDTH-1:0] quo_next;
    logic [dout_WIDTH-1:0] q_narrow;
    logic [din1_WIDTH:0]   rem_val;

    // mag_q doubles as dividend shifter and quotient accumulator: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_comb begin
        mag_in    = bus.din0[din0_WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;
        shifted   = {part_q, mag_q[din0_WIDTH-1]};
        q_bit     = (shifted >= {1'b0, div_q});
        part_next = din1_WIDTH'(q_bit ? (shifted - {1'b0, div_q}) : shifted);
        quo_next  = {mag_q[din0_WIDTH-2:0], q_bit};
        rem_val   = neg_q ? -{1'b0, part_next} : {1'b0, part_next};
    end

`ifdef MYPROJECT_SDIV_SAT_EN
    localparam logic signed [din0_WIDTH:0] FULL_MAX = {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, Q_MAX};
    localparam logic signed [din0_WIDTH:0] FULL_MIN = {{(din0_WIDTH-dout_WIDTH+1){1'b1}}, Q_MIN};
    logic signed [din0_WIDTH:0] q_full;

    always_comb begin
        q_full = neg_q ? -$signed({1'b0, quo_next}) : $signed({1'b0, quo_next});
        if (q_full > FULL_MAX) begin
            q_narrow = Q_MAX;
        end else if (q_full < FULL_MIN) begin
            q_narrow = Q_MIN;
        end else begin
            q_narrow = q_full[dout_WIDTH-1:0];
        end
    end
`else
    // Low bits of a negation equal the negation of the low bits, so wrap is cheap.
    always_comb begin
        q_narrow = neg_q ? -quo_next[dout_WIDTH-1:0] : quo_next[dout_WIDTH-1:0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        part_d      = part_q;
        div_d       = div_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mag_d      = mag_in;
                    neg_d      = bus.din0[din0_WIDTH-1];
                    div_d      = bus.din1;
                    part_d     = '0;
                    in_ready_d = 1'b0;
                    if (bus.din1 == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        dbz_d       = 1'b1;
                        rem_d       = '0;
                        dout_d      = bus.din0[din0_WIDTH-1] ? Q_MIN : Q_MAX;
                        cnt_d       = '0;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            CALC: begin
                mag_d  = quo_next;
                part_d = part_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    dout_d      = q_narrow;
                    rem_d       = rem_val;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            part_q      <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            part_q      <= part_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.rem       = rem_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_myproject_sdiv_22s_8ns_14_seq.sv
// Scoreboard bench for the sequential divider: stimulus pushes hand-computed
// results, a negedge monitor pops and compares them on every output handshake.
module tb_myproject_sdiv_22s_8ns_14_seq;
    localparam int DIN0_W = 22;
    localparam int DIN1_W = 8;
    localparam int DOUT_W = 14;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [DOUT_W-1:0] dout;
        logic [DIN1_W:0]   rem;
        logic              dbz;
        int                lat;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;

    myproject_sdiv_22s_8ns_14_seq_if #(
        .din0_WIDTH(DIN0_W),
        .din1_WIDTH(DIN1_W),
        .dout_WIDTH(DOUT_W)
    ) bus ();

    myproject_sdiv_22s_8ns_14_seq #(
        .din0_WIDTH(DIN0_W),
        .din1_WIDTH(DIN1_W),
        .dout_WIDTH(DOUT_W)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    always #5 ap_clk = ~ap_clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   seen = 1'b0;
    bit   hs_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: compares on first sight, checks hold each DONE cycle, pops on handshake.
    always @(negedge ap_clk) begin
        exp_t e;
        cyc++;
        if (!ap_rst_n) begin
            seen    = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                checkOutput("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
            end
            hs_prev = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_output");
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        checkOutput("dout", 32'(bus.dout), 32'(e.dout));
                        checkOutput("rem", 32'(bus.rem), 32'(e.rem));
                        checkOutput("dbz", 32'(bus.dbz), 32'(e.dbz));
                        checkOutput("latency_edges", 32'(cyc - acc_cyc - 1), 32'(e.lat));
                        seen = 1'b1;
                    end else begin
                        checkOutput("hold", {8'd0, bus.dbz, bus.rem, bus.dout},
                                    {8'd0, e.dbz, e.rem, e.dout});
                    end
                    checkOutput("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        seen    = 1'b0;
                        hs_prev = 1'b1;
                        n_done++;
                    end
                end
            end
        end
    end

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("wait_in_ready");
    endtask

    // Issue one operation, optionally stall the result, and wait for its handshake.
    task automatic applyStimulus(input int d0, input int d1, input int e_dout, input int e_rem,
                                 input bit e_dbz, input int hold);
        exp_t e;
        bit   ok;
        int   done_before;
        waitReady(ok);
        if (!ok) return;
        e.dout = DOUT_W'(e_dout);
        e.rem  = (DIN1_W + 1)'(e_rem);
        e.dbz  = e_dbz;
        e.lat  = (d1 == 0) ? 0 : DIN0_W;
        sb.push_back(e);
        done_before   = n_done;
        bus.out_ready = (hold == 0);
        bus.din0      = DIN0_W'(d0);
        bus.din1      = DIN1_W'(d1);
        bus.in_valid  = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        if (hold > 0) begin
            ok = 1'b0;
            for (int i = 0; i < TIMEOUT; i++) begin
                if (bus.out_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge ap_clk);
                #1;
            end
            if (!ok) failNow("wait_out_valid");
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = (i == hold / 2);
                bus.din0     = DIN0_W'(9);
                bus.din1     = DIN1_W'(3);
                @(posedge ap_clk);
                #1;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (n_done != done_before) begin
                ok = 1'b1;
                break;
            end
            @(posedge ap_clk);
            #1;
        end
        if (!ok) failNow("wait_handshake");
    endtask

    initial begin
        bit ok;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.din0      = '0;
        bus.din1      = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_dout", 32'(bus.dout), 32'd0);
        checkOutput("reset_rem", 32'(bus.rem), 32'd0);
        checkOutput("reset_dbz", 32'(bus.dbz), 32'd0);
        ap_rst_n = 1'b1;

        applyStimulus(1000, 7, 142, 6, 1'b0, 0);
        applyStimulus(-1000, 7, -142, -6, 1'b0, 0);
`ifdef MYPROJECT_SDIV_SAT_EN
        applyStimulus(2097151, 1, 8191, 0, 1'b0, 0);
        applyStimulus(-2097152, 1, -8192, 0, 1'b0, 0);
`else
        applyStimulus(2097151, 1, -1, 0, 1'b0, 0);
        applyStimulus(-2097152, 1, 0, 0, 1'b0, 0);
`endif
        applyStimulus(500, 0, 8191, 0, 1'b1, 0);
        applyStimulus(-5, 0, -8192, 0, 1'b1, 0);
        applyStimulus(0, 0, 8191, 0, 1'b1, 0);
        applyStimulus(0, 5, 0, 0, 1'b0, 0);
        applyStimulus(-7, 2, -3, -1, 1'b0, 0);
        applyStimulus(-3, 200, 0, -3, 1'b0, 0);
        applyStimulus(3, 200, 0, 3, 1'b0, 0);
        applyStimulus(255, 255, 1, 0, 1'b0, 10);

        // Abort an operation ten cycles into CALC; nothing is pushed for it.
        waitReady(ok);
        if (ok) begin
            bus.din0     = DIN0_W'(12345);
            bus.din1     = DIN1_W'(3);
            bus.in_valid = 1'b1;
            @(posedge ap_clk);
            #1;
            bus.in_valid = 1'b0;
            repeat (10) @(posedge ap_clk);
            #3;
            ap_rst_n = 1'b0;
            #1;
            checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
            checkOutput("midreset_dout", 32'(bus.dout), 32'd0);
            repeat (2) @(posedge ap_clk);
            #1;
            ap_rst_n = 1'b1;
        end
        applyStimulus(100, 10, 10, 0, 1'b0, 0);

        repeat (5) @(posedge ap_clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
